// File: rtl/ws2812b_rx.sv
// ws2812b_rx: decodes an asynchronous WS2812B single-wire stream into 24-bit
// pixels (G,R,B, first bit in PIXEL[23]), with pixel index, end-of-frame
// detection on a long low, and an error strobe on malformed pulses.
module ws2812b_rx #(
   parameter int T_MIN_H  = 8,
   parameter int T_THRESH = 30,
   parameter int T_MAX_H  = 60,
   parameter int T_LATCH  = 2500
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        DIN,
   output logic [23:0] PIXEL,
   output logic        PIXEL_VALID,
   output logic [7:0]  PIXEL_IDX,
   output logic        FRAME_DONE,
   output logic [8:0]  FRAME_PIXELS,
   output logic        ERROR
);

   localparam logic [1:0] RST_WAIT = 2'd0;
   localparam logic [1:0] IDLE     = 2'd1;
   localparam logic [1:0] HIGH     = 2'd2;
   localparam logic [1:0] LOW      = 2'd3;

   localparam logic [11:0] MIN_H   = 12'(T_MIN_H);
   localparam logic [11:0] THRESH  = 12'(T_THRESH);
   localparam logic [11:0] MAX_H   = 12'(T_MAX_H);
   localparam logic [11:0] LATCH   = 12'(T_LATCH);
   localparam logic [11:0] CNT_SAT = 12'hFFF;

   logic [1:0]  sync_reg;
   logic        din_s;
   logic        din_prev_reg;
   logic        rise;
   logic        fall;
   logic [11:0] cnt_reg;
   logic [11:0] cnt_next;
   logic        hi_bit;
   logic [1:0]  state_reg;
   logic [23:0] shift_reg;
   logic [4:0]  bit_cnt_reg;
   logic        pend_reg;
   logic [7:0]  idx_reg;
   logic [8:0]  frame_cnt_reg;

   assign din_s  = sync_reg[1];
   assign rise   = din_s & ~din_prev_reg;
   assign fall   = ~din_s & din_prev_reg;
   // A high of T_THRESH samples or more is a one
   assign hi_bit = (cnt_reg >= THRESH);

   // Two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], DIN};
      end
   end

   // Shared run-length counter: restarts at 1 on every edge, saturates at 4095
   always_comb begin
      cnt_next = cnt_reg;
      if (rise || fall) begin
         cnt_next = 12'd1;
      end else if (cnt_reg != CNT_SAT) begin
         cnt_next = cnt_reg + 12'd1;
      end
   end

   // Edge-detect history and run-length counter registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         din_prev_reg <= 1'b0;
         cnt_reg      <= 12'd0;
      end else begin
         din_prev_reg <= din_s;
         cnt_reg      <= cnt_next;
      end
   end

   // Protocol FSM: bit classification, pixel assembly, frame latch and errors
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg     <= RST_WAIT;
         shift_reg     <= 24'd0;
         bit_cnt_reg   <= 5'd0;
         pend_reg      <= 1'b0;
         idx_reg       <= 8'd0;
         frame_cnt_reg <= 9'd0;
         PIXEL         <= 24'd0;
         PIXEL_VALID   <= 1'b0;
         PIXEL_IDX     <= 8'd0;
         FRAME_DONE    <= 1'b0;
         FRAME_PIXELS  <= 9'd0;
         ERROR         <= 1'b0;
      end else begin
         PIXEL_VALID <= 1'b0;
         FRAME_DONE  <= 1'b0;
         ERROR       <= 1'b0;

         // A completed pixel is published one cycle after its last falling edge
         if (pend_reg) begin
            pend_reg    <= 1'b0;
            PIXEL       <= shift_reg;
            PIXEL_IDX   <= idx_reg;
            PIXEL_VALID <= 1'b1;
            idx_reg     <= idx_reg + 8'd1;
            if (frame_cnt_reg != 9'h1FF) begin
               frame_cnt_reg <= frame_cnt_reg + 9'd1;
            end
         end

         case (state_reg)
            RST_WAIT: begin
               // Silent until the line has been low for a full latch time
               if (!din_s && cnt_next == LATCH) begin
                  state_reg <= IDLE;
               end
            end
            IDLE: begin
               if (rise) begin
                  state_reg <= HIGH;
               end
            end
            HIGH: begin
               if (fall) begin
                  if (cnt_reg >= MIN_H) begin
                     shift_reg <= {shift_reg[22:0], hi_bit};
                     if (bit_cnt_reg == 5'd23) begin
                        bit_cnt_reg <= 5'd0;
                        pend_reg    <= 1'b1;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                     end
                     state_reg <= LOW;
                  end else begin
                     // Glitch: abandon the frame and resynchronise on a latch
                     ERROR         <= 1'b1;
                     bit_cnt_reg   <= 5'd0;
                     shift_reg     <= 24'd0;
                     idx_reg       <= 8'd0;
                     frame_cnt_reg <= 9'd0;
                     state_reg     <= RST_WAIT;
                  end
               end else if (cnt_reg == MAX_H) begin
                  // Still high on sample T_MAX_H+1: over-long pulse
                  ERROR         <= 1'b1;
                  bit_cnt_reg   <= 5'd0;
                  shift_reg     <= 24'd0;
                  idx_reg       <= 8'd0;
                  frame_cnt_reg <= 9'd0;
                  state_reg     <= RST_WAIT;
               end
            end
            LOW: begin
               if (rise) begin
                  state_reg <= HIGH;
               end else if (cnt_next == LATCH) begin
                  // End of frame; leftover bits mean a truncated pixel
                  FRAME_DONE    <= 1'b1;
                  FRAME_PIXELS  <= frame_cnt_reg;
                  ERROR         <= (bit_cnt_reg != 5'd0);
                  bit_cnt_reg   <= 5'd0;
                  shift_reg     <= 24'd0;
                  idx_reg       <= 8'd0;
                  frame_cnt_reg <= 9'd0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= RST_WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812b_rx.sv
// tb_ws2812b_rx: drives WS2812B waveforms into ws2812b_rx and compares the
// stream of output strobes against events derived from the pulse rules.
module tb_ws2812b_rx;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        DIN;
   logic [23:0] PIXEL;
   logic        PIXEL_VALID;
   logic [7:0]  PIXEL_IDX;
   logic        FRAME_DONE;
   logic [8:0]  FRAME_PIXELS;
   logic        ERROR;

   always #5 CLK = ~CLK;

   ws2812b_rx dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .DIN          (DIN),
      .PIXEL        (PIXEL),
      .PIXEL_VALID  (PIXEL_VALID),
      .PIXEL_IDX    (PIXEL_IDX),
      .FRAME_DONE   (FRAME_DONE),
      .FRAME_PIXELS (FRAME_PIXELS),
      .ERROR        (ERROR)
   );

   typedef struct packed {
      logic        pv;
      logic        fd;
      logic        er;
      logic [23:0] pix;
      logic [7:0]  idx;
      logic [8:0]  fp;
   } ev_t;

   typedef struct {
      int   hi;
      logic legal;
      logic bitv;
   } vec_t;

   ev_t got_q[$];
   int  cyc_q[$];
   ev_t exp_q[$];
   ev_t mon_e;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   int last_set_cyc = 0;
   int last_fall_cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Record every cycle that carries a strobe; fields are masked by strobe
   always @(negedge CLK) begin
      if (RESET_N === 1'b1 && (PIXEL_VALID || FRAME_DONE || ERROR)) begin
         mon_e = '0;
         mon_e.pv = PIXEL_VALID;
         mon_e.fd = FRAME_DONE;
         mon_e.er = ERROR;
         if (PIXEL_VALID) begin
            mon_e.pix = PIXEL;
            mon_e.idx = PIXEL_IDX;
         end
         if (FRAME_DONE) mon_e.fp = FRAME_PIXELS;
         got_q.push_back(mon_e);
         cyc_q.push_back(cyc);
      end
   end

   task automatic hold(input logic v, input int n);
      @(posedge CLK);
      #1;
      DIN = v;
      last_set_cyc = cyc;
      if (v == 1'b0) last_fall_cyc = cyc;
      repeat (n - 1) @(posedge CLK);
   endtask

   task automatic send_bits(input logic [23:0] d, input int nbits,
                            input int h0, input int l0, input int h1, input int l1);
      for (int i = 0; i < nbits; i++) begin
         if (d[23 - i]) begin
            hold(1'b1, h1);
            hold(1'b0, l1);
         end else begin
            hold(1'b1, h0);
            hold(1'b0, l0);
         end
      end
   endtask

   task automatic send_bits_rand(input logic [23:0] d, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         if (d[23 - i]) hold(1'b1, int'($urandom_range(30, 60)));
         else           hold(1'b1, int'($urandom_range(8, 29)));
         hold(1'b0, int'($urandom_range(1, 20)));
      end
   endtask

   task automatic latch();
      hold(1'b0, 2510);
   endtask

   task automatic exp_pix(input logic [23:0] d, input logic [7:0] idx);
      ev_t e;
      e = '0;
      e.pv = 1'b1;
      e.pix = d;
      e.idx = idx;
      exp_q.push_back(e);
   endtask

   task automatic exp_frame(input logic [8:0] n, input logic err);
      ev_t e;
      e = '0;
      e.fd = 1'b1;
      e.er = err;
      e.fp = n;
      exp_q.push_back(e);
   endtask

   task automatic exp_err();
      ev_t e;
      e = '0;
      e.er = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic check_latency(input string name, input int ref_cyc, input int want);
      n_vec++;
      if (cyc_q.size() == 0) begin
         n_err++;
         $display("FAIL %s latency: got no strobe, expected one %0d cycles after the edge", name, want);
      end else if (cyc_q[0] - ref_cyc != want) begin
         n_err++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc_q[0] - ref_cyc, want);
      end
   endtask

   task automatic check_events(input string name);
      ev_t g;
      ev_t x;
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL %s event count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         g = got_q[i];
         x = exp_q[i];
         n_vec++;
         if (g !== x) begin
            n_err++;
            $display("FAIL %s event %0d: got pv=%b fd=%b er=%b pix=%h idx=%0d fp=%0d, expected pv=%b fd=%b er=%b pix=%h idx=%0d fp=%0d",
                     name, i, g.pv, g.fd, g.er, g.pix, g.idx, g.fp, x.pv, x.fd, x.er, x.pix, x.idx, x.fp);
         end
      end
      $display("vector %s: %0d events seen, %0d expected", name, got_q.size(), exp_q.size());
      got_q.delete();
      cyc_q.delete();
      exp_q.delete();
   endtask

   task automatic check_zero_outputs(input string name);
      n_vec++;
      if ({PIXEL, PIXEL_VALID, PIXEL_IDX, FRAME_DONE, FRAME_PIXELS, ERROR} !== 45'd0) begin
         n_err++;
         $display("FAIL %s outputs: got pix=%h pv=%b idx=%0d fd=%b fp=%0d er=%b, expected all 0",
                  name, PIXEL, PIXEL_VALID, PIXEL_IDX, FRAME_DONE, FRAME_PIXELS, ERROR);
      end
   endtask

   vec_t tbl[7];

   initial begin
      int ref_cyc;
      int npix;
      int part;
      logic [23:0] d;

      tbl[0] = '{hi: 7,  legal: 1'b0, bitv: 1'b0};
      tbl[1] = '{hi: 8,  legal: 1'b1, bitv: 1'b0};
      tbl[2] = '{hi: 29, legal: 1'b1, bitv: 1'b0};
      tbl[3] = '{hi: 30, legal: 1'b1, bitv: 1'b1};
      tbl[4] = '{hi: 60, legal: 1'b1, bitv: 1'b1};
      tbl[5] = '{hi: 61, legal: 1'b0, bitv: 1'b0};
      tbl[6] = '{hi: 3,  legal: 1'b0, bitv: 1'b0};

      DIN = 1'b0;
      RESET_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check_zero_outputs("reset");
      RESET_N = 1'b1;

      // Boot: the receiver stays silent while waiting for the first latch
      latch();
      check_events("boot");

      // Single pixel 0xFF0000, 40/22 ones, 20/42 zeros
      send_bits(24'hFF0000, 24, 20, 42, 40, 22);
      ref_cyc = last_fall_cyc;
      latch();
      check_latency("pix_ff0000", ref_cyc, 4);
      exp_pix(24'hFF0000, 8'd0);
      exp_frame(9'd1, 1'b0);
      check_events("pix_ff0000");

      // Three pixels with 20/45 and 40/25 timings
      send_bits(24'h123456, 24, 20, 45, 40, 25);
      send_bits(24'hABCDEF, 24, 20, 45, 40, 25);
      send_bits(24'h000001, 24, 20, 45, 40, 25);
      latch();
      exp_pix(24'h123456, 8'd0);
      exp_pix(24'hABCDEF, 8'd1);
      exp_pix(24'h000001, 8'd2);
      exp_frame(9'd3, 1'b0);
      check_events("three_pix");

      // Reset after bit 10: outputs clear at once, decoding waits for a latch
      send_bits(24'h00FF00, 10, 20, 45, 40, 25);
      #3;
      RESET_N = 1'b0;
      #1;
      check_zero_outputs("reset_mid");
      @(negedge CLK);
      #2;
      RESET_N = 1'b1;
      send_bits(24'h00FF00, 24, 20, 45, 40, 25);
      latch();
      check_events("reset_no_decode");
      send_bits(24'h00FF00, 24, 20, 45, 40, 25);
      latch();
      exp_pix(24'h00FF00, 8'd0);
      exp_frame(9'd1, 1'b0);
      check_events("reset_recover");

      // 5-cycle glitch mid-pixel
      d = 24'($urandom);
      send_bits_rand(d, 10);
      hold(1'b1, 5);
      hold(1'b0, 20);
      send_bits_rand(d, 13);
      latch();
      exp_err();
      check_events("glitch");
      d = 24'($urandom);
      send_bits_rand(d, 24);
      latch();
      exp_pix(d, 8'd0);
      exp_frame(9'd1, 1'b0);
      check_events("glitch_recover");

      // Line stuck high for 100 cycles; afterwards a pixel must be ignored
      hold(1'b1, 100);
      ref_cyc = last_set_cyc;
      hold(1'b0, 50);
      send_bits(24'hFFFFFF, 24, 12, 4, 40, 4);
      latch();
      check_latency("stuck_high", ref_cyc, 63);
      exp_err();
      check_events("stuck_high");

      // Truncated pixel: 12 bits then latch
      send_bits(24'hA5A5A5, 12, 20, 45, 40, 25);
      latch();
      exp_frame(9'd0, 1'b1);
      check_events("partial12");

      // Pulse-width classification table: first bit varies, rest are zeros
      for (int v = 0; v < 7; v++) begin
         hold(1'b1, tbl[v].hi);
         hold(1'b0, 4);
         send_bits(24'h000000, 23, 12, 4, 40, 4);
         latch();
         if (tbl[v].legal) begin
            exp_pix({tbl[v].bitv, 23'd0}, 8'd0);
            exp_frame(9'd1, 1'b0);
         end else begin
            exp_err();
         end
         check_events($sformatf("width_%0d", tbl[v].hi));
      end

      // Random frames against the pixel-list model
      for (int f = 0; f < 4; f++) begin
         npix = int'($urandom_range(1, 2));
         for (int p = 0; p < npix; p++) begin
            d = 24'($urandom);
            send_bits_rand(d, 24);
            exp_pix(d, 8'(p));
         end
         part = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 23)) : 0;
         if (part != 0) send_bits_rand(24'($urandom), part);
         latch();
         exp_frame(9'(npix), part != 0);
         check_events($sformatf("rand_%0d", f));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
